mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 SHALL have parameter MAX_DATA_BURST, default 2, max consecutive data grants while fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 255, cycles waiting for mem_ready before abort.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports i_req in 1, i_addr in 32: instruction fetch request and word address.
REQ-006 SHALL have ports i_rdata out 32, i_valid out 1: fetch data and one-cycle completion pulse.
REQ-007 SHALL have ports d_req in 1, d_we in 4, d_addr in 32, d_wdata in 32: data request, byte write enables (0 = read), address, store data.
REQ-008 SHALL have ports d_rdata out 32, d_valid out 1: load data and one-cycle completion pulse.
REQ-009 SHALL have ports mem_req out 1, mem_we out 4, mem_addr out 32, mem_wdata out 32 toward the single memory port.
REQ-010 SHALL have ports mem_rdata in 32, mem_ready in 1: memory response, ready = transfer done this cycle.
REQ-011 SHALL have ports stall out 1 (pipeline hold) and bus_error out 1 (one-cycle timeout pulse).
Function
REQ-012 SHALL implement FSM states IDLE, INSTR, DATA; exactly one transaction outstanding.
REQ-013 IDLE: d_req and i_req both low -> stay IDLE, mem_req 0.
REQ-014 IDLE: grant data when d_req=1, unless burst count = MAX_DATA_BURST and i_req=1, then grant fetch.
REQ-015 IDLE: grant fetch when i_req=1 and data not granted.
REQ-016 On grant, register address/we/wdata into mem_* and assert mem_req next cycle; enter INSTR or DATA.
REQ-017 mem_addr, mem_we, mem_wdata, mem_req SHALL stay stable while in INSTR/DATA until mem_ready or timeout.
REQ-018 Fetch mem_we SHALL be 4'b0000; mem_wdata 0.
REQ-019 mem_ready=1 in INSTR: capture mem_rdata to i_rdata, pulse i_valid next cycle, return IDLE, drop mem_req.
REQ-020 mem_ready=1 in DATA: capture mem_rdata to d_rdata only when d_we=0, pulse d_valid next cycle, return IDLE.
REQ-021 Minimum latency: request sampled cycle N, mem_req cycle N+1, valid pulse cycle N+2 with same-cycle ready.
REQ-022 mem_ready while IDLE SHALL be ignored.
REQ-023 i_rdata/d_rdata SHALL hold last captured value between pulses.
REQ-024 Requester dropping req mid-transaction SHALL NOT abort it; valid still pulses.
REQ-025 Burst counter: +1 per data grant (saturate at MAX_DATA_BURST), clear on fetch grant or when i_req=0 in IDLE.
REQ-026 Wait counter: clear on grant, +1 per cycle in INSTR/DATA without mem_ready.
REQ-027 Wait counter reaching TIMEOUT: drop mem_req, pulse bus_error and the owner's valid (rdata unchanged), return IDLE.
REQ-028 stall SHALL be combinational: d_req=1 and d_valid=0.
REQ-029 Same cycle d_valid pulse and new d_req: new request arbitrated normally in IDLE.
Reset
REQ-030 reset low SHALL immediately force IDLE, clear both counters, all outputs 0 (stall follows d_req).
REQ-031 Reset mid-transaction SHALL drop mem_req asynchronously; no valid pulse for the aborted access.
REQ-032 Operation resumes first rising edge after reset deasserts.
Structure
REQ-033 Enum arb_state_t {ARB_IDLE, ARB_INSTR, ARB_DATA} SHALL live in my_pkg.
REQ-034 Single module, no sub-module; counters width $clog2 of parameters + 1.
Verification
REQ-035 Fetch only: i_addr=0x100, mem_ready same cycle, mem_rdata=0x00000013 -> i_valid at N+2, i_rdata=0x00000013.
REQ-036 Simultaneous: i_req, d_req (d_addr=0x2000, d_we=0) -> data first, fetch served immediately after.
REQ-037 d_req held 5 transactions, i_req pending, MAX_DATA_BURST=2 -> grant order D,D,I,D,D.
REQ-038 Store d_we=4'b1111, d_wdata=0xDEADBEEF, ready after 3 waits -> mem_* stable 4 cycles, stall high until d_valid, d_rdata unchanged.
REQ-039 mem_ready never asserted, TIMEOUT=8 -> bus_error and d_valid pulse after 8 waits, FSM IDLE.
REQ-040 reset low during DATA with mem_req=1 -> mem_req 0 at once, no d_valid, IDLE after release.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// my_pkg : shared types for mem_arbiter (arbiter states, counter sizing)
// Revision: 1.0
// ------------------------------------------------------------------
package my_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_INSTR = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  // Counter width able to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arbiter_if : fetch, data and memory-port signals of mem_arbiter
// Revision: 1.0
// ------------------------------------------------------------------
interface mem_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;

  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;

  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        stall;
  logic        bus_error;

  // Arbiter side
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_valid, d_rdata, d_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, stall, bus_error
  );

  // Requester and memory side
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_valid, d_rdata, d_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall, bus_error
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_arbiter : shares one memory port between instruction fetch and
// data access, one transaction outstanding, with data-burst limit and timeout.
// Revision: 1.0
// ------------------------------------------------------------------
module mem_arbiter
  import my_pkg::*;
#(
  parameter int MAX_DATA_BURST = 2,
  parameter int TIMEOUT        = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam int BURST_W = cnt_width(MAX_DATA_BURST);
  localparam int WAIT_W  = cnt_width(TIMEOUT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);
  // Abort on the TIMEOUT-th consecutive busy cycle without mem_ready.
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mem_req_q, mem_req_d;
  logic [3:0]          mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         i_rdata_q, i_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                i_valid_q, i_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                bus_error_q, bus_error_d;
  logic                grant_data, grant_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      burst_q     <= '0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    bus_error_d = 1'b0;
    // Data wins unless it has already used its burst allowance while a fetch waits.
    grant_data  = bus.d_req && !(bus.i_req && (burst_q == BURST_MAX));
    grant_instr = bus.i_req && !grant_data;

    case (state_q)
      ARB_IDLE: begin
        if (grant_data) begin
          state_d     = ARB_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          wait_d      = '0;
          if (!bus.i_req) begin
            burst_d = '0;
          end else if (burst_q != BURST_MAX) begin
            burst_d = burst_q + BURST_W'(1);
          end
        end else if (grant_instr) begin
          state_d     = ARB_INSTR;
          mem_req_d   = 1'b1;
          mem_we_d    = 4'b0000;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = '0;
          wait_d      = '0;
          burst_d     = '0;
        end else begin
          burst_d = '0;
        end
      end

      ARB_INSTR, ARB_DATA: begin
        if (bus.mem_ready) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          if (state_q == ARB_INSTR) begin
            i_valid_d = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (mem_we_q == 4'b0000) begin
              d_rdata_d = bus.mem_rdata;
            end
          end
        end else if (wait_q == WAIT_LAST) begin
          // Timeout completes the access toward its owner with stale read data.
          state_d     = ARB_IDLE;
          mem_req_d   = 1'b0;
          bus_error_d = 1'b1;
          if (state_q == ARB_INSTR) begin
            i_valid_d = 1'b1;
          end else begin
            d_valid_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.bus_error = bus_error_q;
  assign bus.stall     = bus.d_req && !d_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mem_arbiter : directed vector table, corner sequences and a
// randomized run checked against a transaction-level arbiter model.
// ------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int MAX_BURST = 2;
  localparam int TMO       = 8;

  logic clk = 1'b0;
  logic reset;
  mem_arbiter_if bus();

  mem_arbiter #(.MAX_DATA_BURST(MAX_BURST), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] hold_i = '0;
  logic [31:0] hold_d = '0;

  typedef struct {
    logic        is_data;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        drop_early;
    logic [31:0] exp_rdata;
  } row_t;

  row_t rows[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic run_row(input row_t r);
    @(negedge clk);
    if (r.is_data) begin
      bus.d_req = 1'b1; bus.d_we = r.we; bus.d_addr = r.addr; bus.d_wdata = r.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = r.addr;
    end
    for (int k = 0; k <= r.waits; k++) begin
      @(negedge clk);
      chk("row_mem_req", 32'(bus.mem_req), 32'd1);
      chk("row_mem_addr", bus.mem_addr, r.addr);
      chk("row_mem_we", 32'(bus.mem_we), r.is_data ? 32'(r.we) : 32'd0);
      chk("row_mem_wdata", bus.mem_wdata, r.is_data ? r.wdata : 32'd0);
      chk("row_no_early_valid", 32'({bus.i_valid, bus.d_valid}), 32'd0);
      if (r.is_data && !(r.drop_early && k > 0)) chk("row_stall_busy", 32'(bus.stall), 32'd1);
      if (r.drop_early && k == 0) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end
      bus.mem_ready = (k == r.waits);
      bus.mem_rdata = (k == r.waits) ? r.rdata : $urandom;
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("row_mem_req_drop", 32'(bus.mem_req), 32'd0);
    if (r.is_data) begin
      chk("row_d_valid", 32'(bus.d_valid), 32'd1);
      chk("row_i_valid_quiet", 32'(bus.i_valid), 32'd0);
      chk("row_d_rdata", bus.d_rdata, r.exp_rdata);
      chk("row_stall_at_valid", 32'(bus.stall), 32'd0);
      hold_d = r.exp_rdata;
    end else begin
      chk("row_i_valid", 32'(bus.i_valid), 32'd1);
      chk("row_d_valid_quiet", 32'(bus.d_valid), 32'd0);
      chk("row_i_rdata", bus.i_rdata, r.exp_rdata);
      chk("row_d_rdata_hold", bus.d_rdata, hold_d);
      hold_i = r.exp_rdata;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    chk("row_valid_one_cycle", 32'({bus.i_valid, bus.d_valid}), 32'd0);
    chk("row_idle_mem_req", 32'(bus.mem_req), 32'd0);
  endtask

  task automatic serve(output int kind);
    int n;
    logic [31:0] resp;
    n = 0;
    kind = -1;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.mem_req !== 1'b1) begin
      chk("grant_wait", 32'(bus.mem_req), 32'd1);
      return;
    end
    kind = bus.mem_addr[13] ? 1 : 0;
    resp = $urandom;
    bus.mem_ready = 1'b1; bus.mem_rdata = resp;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    if (kind == 1) begin
      chk("burst_d_valid", 32'(bus.d_valid), 32'd1);
      chk("burst_d_rdata", bus.d_rdata, resp);
      hold_d = resp;
      bus.d_addr = bus.d_addr + 32'd4;
    end else begin
      chk("burst_i_valid", 32'(bus.i_valid), 32'd1);
      chk("burst_i_rdata", bus.i_rdata, resp);
      hold_i = resp;
      bus.i_req = 1'b0;
    end
  endtask

  // Randomized-run model state: previous-cycle inputs and the transaction in flight.
  logic        p_busy, p_ready, p_ireq, p_dreq;
  logic [31:0] p_iaddr, p_daddr, p_dwdata;
  logic [3:0]  p_dwe;
  logic        t_data;
  logic [3:0]  t_we;
  logic [31:0] t_addr, t_wdata, resp_r;
  int          busy_len, waits, streak;
  logic        e_req, e_iv, e_dv, e_be;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int busy;
    int exp_order[5];
    exp_order = '{1, 1, 0, 1, 1};

    rows[0] = '{1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h0000_0013, 0, 1'b0, 32'h0000_0013};
    rows[1] = '{1'b1, 4'h0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D};
    rows[2] = '{1'b1, 4'hF, 32'h0000_2004, 32'hDEAD_BEEF, 32'h1111_1111, 3, 1'b0, 32'hCAFE_F00D};
    rows[3] = '{1'b0, 4'h0, 32'h0000_0104, 32'h0, 32'h0010_0093, 2, 1'b1, 32'h0010_0093};
    rows[4] = '{1'b1, 4'h0, 32'h0000_2008, 32'h0, 32'h55AA_0FF0, 0, 1'b1, 32'h55AA_0FF0};
    rows[5] = '{1'b1, 4'h3, 32'h0000_200C, 32'h1234_5678, 32'h0000_9999, 1, 1'b0, 32'h55AA_0FF0};

    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_valids", 32'({bus.i_valid, bus.d_valid, bus.bus_error}), 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_mem_req", 32'(bus.mem_req), 32'd0);

    for (int r = 0; r < 6; r++) run_row(rows[r]);

    // Simultaneous requests: data first, fetch right after.
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_addr = 32'h2000; bus.d_we = 4'h0;
    @(negedge clk);
    chk("simul_first_addr", bus.mem_addr, 32'h2000);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_00A1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("simul_d_valid", 32'(bus.d_valid), 32'd1);
    chk("simul_d_rdata", bus.d_rdata, 32'h0000_00A1);
    hold_d = 32'h0000_00A1;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("simul_fetch_req", 32'(bus.mem_req), 32'd1);
    chk("simul_fetch_addr", bus.mem_addr, 32'h300);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_00B2;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    chk("simul_i_valid", 32'(bus.i_valid), 32'd1);
    chk("simul_i_rdata", bus.i_rdata, 32'h0000_00B2);
    hold_i = 32'h0000_00B2;
    bus.i_req = 1'b0;
    @(negedge clk);

    // Burst limit: D,D,I,D,D with data held and a fetch pending.
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_addr = 32'h2100; bus.d_we = 4'h0;
    for (int t = 0; t < 5; t++) begin
      serve(kind);
      chk($sformatf("burst_order_%0d", t), 32'(kind), 32'(exp_order[t]));
    end
    idle_inputs();
    @(negedge clk);

    // Timeout: memory never answers.
    bus.d_req = 1'b1; bus.d_addr = 32'h2200; bus.d_we = 4'h0;
    busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b1) break;
      busy++;
    end
    chk("tmo_busy_cycles", 32'(busy), 32'(TMO));
    chk("tmo_bus_error", 32'(bus.bus_error), 32'd1);
    chk("tmo_d_valid", 32'(bus.d_valid), 32'd1);
    chk("tmo_i_valid_quiet", 32'(bus.i_valid), 32'd0);
    chk("tmo_d_rdata_hold", bus.d_rdata, hold_d);
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("tmo_error_one_cycle", 32'(bus.bus_error), 32'd0);
    chk("tmo_idle", 32'(bus.mem_req), 32'd0);
    // Stray ready while idle must be ignored.
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ready_valid", 32'({bus.i_valid, bus.d_valid}), 32'd0);
      chk("idle_ready_mem_req", 32'(bus.mem_req), 32'd0);
      chk("idle_ready_i_rdata", bus.i_rdata, hold_i);
      chk("idle_ready_d_rdata", bus.d_rdata, hold_d);
    end
    bus.mem_ready = 1'b0;

    // Reset in the middle of a data access.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_addr = 32'h2300; bus.d_we = 4'h0;
    @(negedge clk);
    chk("rstmid_busy", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_mem_req_async", 32'(bus.mem_req), 32'd0);
    chk("rstmid_mem_addr", bus.mem_addr, 32'd0);
    chk("rstmid_stall_follows", 32'(bus.stall), 32'd1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_no_valid", 32'({bus.i_valid, bus.d_valid}), 32'd0);
    chk("rstmid_d_rdata", bus.d_rdata, 32'd0);
    chk("rstmid_i_rdata", bus.i_rdata, 32'd0);
    bus.d_req = 1'b0;
    #1;
    chk("rstmid_stall_low", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    hold_i = '0; hold_d = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstrel_no_valid", 32'({bus.i_valid, bus.d_valid, bus.mem_req}), 32'd0);
    end
    run_row(rows[0]);

    // Randomized run against the transaction model.
    idle_inputs();
    @(negedge clk);
    p_busy = 0; p_ready = 0; p_ireq = 0; p_dreq = 0;
    p_iaddr = '0; p_daddr = '0; p_dwdata = '0; p_dwe = '0;
    t_data = 0; t_we = '0; t_addr = '0; t_wdata = '0; resp_r = '0;
    busy_len = 0; waits = 0; streak = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      e_iv = 0; e_dv = 0; e_be = 0; e_req = 0;
      if (p_busy) begin
        if (p_ready || busy_len == TMO) begin
          if (t_data) e_dv = 1; else e_iv = 1;
          if (!p_ready) e_be = 1;
          else if (!t_data) hold_i = resp_r;
          else if (t_we == 4'h0) hold_d = resp_r;
        end else begin
          e_req = 1;
        end
      end else begin
        if (p_dreq && !(p_ireq && streak == MAX_BURST)) begin
          e_req = 1; t_data = 1; t_we = p_dwe; t_addr = p_daddr; t_wdata = p_dwdata;
          streak = p_ireq ? ((streak < MAX_BURST) ? streak + 1 : streak) : 0;
        end else if (p_ireq) begin
          e_req = 1; t_data = 0; t_we = 4'h0; t_addr = p_iaddr; t_wdata = '0;
          streak = 0;
        end else begin
          streak = 0;
        end
        if (e_req) busy_len = 0;
      end

      chk("rnd_mem_req", 32'(bus.mem_req), 32'(e_req));
      chk("rnd_i_valid", 32'(bus.i_valid), 32'(e_iv));
      chk("rnd_d_valid", 32'(bus.d_valid), 32'(e_dv));
      chk("rnd_bus_error", 32'(bus.bus_error), 32'(e_be));
      chk("rnd_i_rdata", bus.i_rdata, hold_i);
      chk("rnd_d_rdata", bus.d_rdata, hold_d);
      chk("rnd_stall", 32'(bus.stall), 32'(bus.d_req && !e_dv));
      if (e_req) begin
        chk("rnd_mem_addr", bus.mem_addr, t_addr);
        chk("rnd_mem_we", 32'(bus.mem_we), 32'(t_we));
        chk("rnd_mem_wdata", bus.mem_wdata, t_wdata);
        busy_len++;
      end

      if (bus.i_req) begin
        if (e_iv) begin
          bus.i_req = $urandom_range(0, 1) == 1;
          bus.i_addr = 32'h400 + 32'(4 * $urandom_range(0, 31));
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.i_req = 1'b1;
        bus.i_addr = 32'h400 + 32'(4 * $urandom_range(0, 31));
      end
      if ((bus.d_req && e_dv) || (!bus.d_req && $urandom_range(0, 2) == 0)) begin
        bus.d_req = bus.d_req ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.d_addr = 32'h2000 + 32'(4 * $urandom_range(0, 31));
        bus.d_we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        bus.d_wdata = $urandom;
      end

      if (e_req) begin
        if (busy_len == 1) waits = ($urandom_range(0, 15) == 0) ? 50 : $urandom_range(0, 3);
        bus.mem_ready = (busy_len - 1 == waits);
        resp_r = $urandom;
        bus.mem_rdata = resp_r;
      end else begin
        bus.mem_ready = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end

      p_busy = e_req; p_ready = bus.mem_ready;
      p_ireq = bus.i_req; p_iaddr = bus.i_addr;
      p_dreq = bus.d_req; p_daddr = bus.d_addr; p_dwe = bus.d_we; p_dwdata = bus.d_wdata;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
